// File: rtl/ldw_pkg.sv
// ldw_pkg -- shared CPU pipeline constants and types.
//   DATA_W       : datapath width
//   REG_W        : register-file index width
//   CNT_W        : MEM-stage wait counter width
//   LDW_TIMEOUT  : default MEM-stage bus timeout, in BUSY cycles
//   mem_state_t  : MEM-stage bus FSM state encoding
package ldw_pkg;

    localparam int DATA_W      = 32;
    localparam int REG_W       = 5;
    localparam int CNT_W       = 4;
    localparam int LDW_TIMEOUT = 15;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Word accesses only: the low two address bits must be zero.
    function automatic logic word_aligned(input logic [DATA_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ldw_MWReg.sv
// ldw_MWReg -- MEM/WB pipeline register.
//   clk, clrn                         : clock, async active-low reset
//   ld                                : 1 = capture inputs, 0 = capture a bubble
//   wreg, m2reg, mo, alu, rn          : next-stage values from the MEM stage
//   wwreg, wm2reg, wmo, walu, wrn     : registered values toward WB
// The register updates every cycle; a stalled or faulted access becomes
// an all-zero bubble so WB never writes the register file for it.
module ldw_MWReg
    import ldw_pkg::*;
(
    input  logic              clk,
    input  logic              clrn,
    input  logic              ld,
    input  logic              wreg,
    input  logic              m2reg,
    input  logic [DATA_W-1:0] mo,
    input  logic [DATA_W-1:0] alu,
    input  logic [REG_W-1:0]  rn,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [DATA_W-1:0] wmo,
    output logic [DATA_W-1:0] walu,
    output logic [REG_W-1:0]  wrn
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wmo    <= '0;
            walu   <= '0;
            wrn    <= '0;
        end else if (ld) begin
            wwreg  <= wreg;
            wm2reg <= m2reg;
            wmo    <= mo;
            walu   <= alu;
            wrn    <= rn;
        end else begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wmo    <= '0;
            walu   <= '0;
            wrn    <= '0;
        end
    end

endmodule

// File: rtl/ldw_mem_stage.sv
// ldw_mem_stage -- MEM pipeline stage with a handshaked data bus.
//   clk, clrn                       : clock, async active-low reset
//   mwreg, mm2reg, mwmem, malu,
//   mb, mrn                         : EX/MEM register contents
//   d_req, d_we, d_addr, d_wdata    : data-bus request (all zero when idle)
//   d_ack, d_rdata                  : data-bus completion and load data
//   mem_stall                       : freeze PC, IF/ID, ID/EX, EX/MEM
//   wwreg, wm2reg, wmo, walu, wrn   : MEM/WB register outputs
//   bus_err                         : one-cycle pulse on misalignment/timeout
// Parameter TIMEOUT: BUSY cycles allowed without d_ack (1..16).
module ldw_mem_stage
    import ldw_pkg::*;
#(
    parameter int TIMEOUT = LDW_TIMEOUT
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic              mwmem,
    input  logic [DATA_W-1:0] malu,
    input  logic [DATA_W-1:0] mb,
    input  logic [REG_W-1:0]  mrn,
    output logic              d_req,
    output logic              d_we,
    output logic [DATA_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_wdata,
    input  logic              d_ack,
    input  logic [DATA_W-1:0] d_rdata,
    output logic              mem_stall,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [DATA_W-1:0] wmo,
    output logic [DATA_W-1:0] walu,
    output logic [REG_W-1:0]  wrn,
    output logic              bus_err
);

    // The counter is cleared on entry to BUSY, so it reads k-1 during the
    // k-th BUSY cycle; the TIMEOUT-th BUSY cycle is the last one allowed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    mem_state_t       state;
    logic [CNT_W-1:0] wait_cnt;

    // Request captured in the IDLE cycle and replayed unchanged while BUSY.
    logic [DATA_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              we_p0;

    logic mem_op, is_load, both_set, aligned;
    logic idle_req, idle_misal, busy_done, busy_tmo;
    logic req_c, mw_ld;
    logic              mw_wreg, mw_m2reg;
    logic [DATA_W-1:0] mw_mo;

    assign mem_op   = mm2reg | mwmem;
    assign both_set = mm2reg & mwmem;
    assign is_load  = mm2reg & ~mwmem;   // store wins when both are set
    assign aligned  = word_aligned(malu);

    assign idle_req   = (state == IDLE) & mem_op & aligned;
    assign idle_misal = (state == IDLE) & mem_op & ~aligned;
    assign busy_done  = (state == BUSY) & d_ack;   // ack beats timeout
    assign busy_tmo   = (state == BUSY) & ~d_ack & (wait_cnt == CNT_LAST);

    // Bus outputs are combinational so the request starts in the IDLE cycle;
    // gating with clrn keeps them quiet while reset is held.
    always_comb begin
        req_c     = clrn & (idle_req | ((state == BUSY) & ~busy_tmo));
        d_req     = req_c;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        if (req_c) begin
            if (state == IDLE) begin
                d_we    = mwmem;
                d_addr  = malu;
                d_wdata = mb;
            end else begin
                d_we    = we_p0;
                d_addr  = addr_p0;
                d_wdata = wdata_p0;
            end
        end
        mem_stall = clrn & (idle_req | ((state == BUSY) & ~d_ack & ~busy_tmo));
        bus_err   = clrn & (idle_misal | busy_tmo);
    end

    // MEM/WB load selection: pass the op through on a non-memory cycle or on
    // completion, otherwise insert a bubble.
    always_comb begin
        mw_ld    = ((state == IDLE) & ~mem_op) | busy_done;
        mw_wreg  = mwreg & ~both_set;
        mw_m2reg = mm2reg & ~both_set;
        mw_mo    = (busy_done & is_load) ? d_rdata : '0;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_req) begin
                        state    <= BUSY;
                        wait_cnt <= '0;
                    end
                end
                BUSY: begin
                    wait_cnt <= sat_inc(wait_cnt);
                    if (busy_done | busy_tmo)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request capture: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            addr_p0  <= malu;
            wdata_p0 <= mb;
            we_p0    <= mwmem;
        end
    end

    ldw_MWReg u_mwreg (
        .clk    (clk),
        .clrn   (clrn),
        .ld     (mw_ld),
        .wreg   (mw_wreg),
        .m2reg  (mw_m2reg),
        .mo     (mw_mo),
        .alu    (malu),
        .rn     (mrn),
        .wwreg  (wwreg),
        .wm2reg (wm2reg),
        .wmo    (wmo),
        .walu   (walu),
        .wrn    (wrn)
    );

endmodule

// File: doc/ldw_mem_stage.md
LDW_MEM_STAGE -- requirements
Module: ldw_mem_stage

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have port: clrn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have inputs from the EX/MEM register: mwreg 1 (register write), mm2reg 1 (load), mwmem 1 (store), malu 32 (effective address / ALU result), mb 32 (store data), mrn 5 (destination register).
REQ-004 SHALL have data-bus outputs: d_req 1 (access request), d_we 1 (write strobe), d_addr 32 (word address), d_wdata 32 (store data).
REQ-005 SHALL have data-bus inputs: d_ack 1 (access complete), d_rdata 32 (load data, valid while d_ack=1).
REQ-006 SHALL have output mem_stall 1: freeze PC, IF/ID, ID/EX and EX/MEM registers.
REQ-007 SHALL have MEM/WB register outputs: wwreg 1, wm2reg 1, wmo 32 (load data), walu 32, wrn 5.
REQ-008 SHALL have output bus_err 1: one-cycle pulse on access fault.
REQ-009 SHALL have parameter TIMEOUT, default 15: maximum BUSY cycles without d_ack.

Function
REQ-010 Memory op: mm2reg=1 or mwmem=1; non-memory op otherwise.
REQ-011 FSM states SHALL be IDLE and BUSY.
REQ-012 IDLE, non-memory op: d_req=0, mem_stall=0; the MEM/WB register loads mwreg, mm2reg, malu, mrn at the edge; wmo loads 0.
REQ-013 IDLE, aligned memory op (malu[1:0]=00): d_req=1, d_addr=malu, d_we=mwmem, d_wdata=mb, mem_stall=1; next state BUSY; the MEM/WB register loads a bubble (wwreg=0, wm2reg=0).
REQ-014 BUSY: d_req, d_addr, d_we and d_wdata SHALL hold the IDLE-cycle values unchanged; a wait counter increments every cycle.
REQ-015 BUSY with d_ack=0: mem_stall=1; the MEM/WB register loads a bubble.
REQ-016 BUSY with d_ack=1: mem_stall=0 in that same cycle; at the edge the MEM/WB register loads mwreg, mm2reg, malu and mrn; wmo loads d_rdata for a load and 0 for a store; next state IDLE.
REQ-017 d_ack SHALL be ignored in IDLE; the minimum access therefore takes 2 cycles.
REQ-018 Both mm2reg=1 and mwmem=1: the op SHALL be treated as a store, and wwreg and wm2reg SHALL be forced to 0 on completion.
REQ-019 Misaligned memory op (malu[1:0]!=00) in IDLE: no request is issued, bus_err=1 for that cycle, mem_stall=0, the MEM/WB register loads a bubble, state stays IDLE.
REQ-020 Timeout: when the counter reaches TIMEOUT in BUSY with d_ack=0, that cycle SHALL drop d_req and assert bus_err=1 and mem_stall=0; the MEM/WB register loads a bubble; next state IDLE.
REQ-021 d_ack arriving in the same cycle as the timeout SHALL count as a completion (ack wins), with no bus_err.
REQ-022 The wait counter SHALL be 4 bits, clear on entry to BUSY, and never wrap.
REQ-023 All d_* outputs SHALL be 0 whenever d_req=0.

Reset
REQ-024 clrn=0 SHALL immediately force state IDLE, counter 0, d_req=0, bus_err=0, and wwreg, wm2reg, wmo, walu, wrn all 0, regardless of clk.
REQ-025 Reset during BUSY SHALL abandon the access; a d_ack arriving after reset release SHALL be ignored, since the block is in IDLE.

Structure
REQ-026 State encodings and the default TIMEOUT SHALL live in the shared CPU package, alongside the other pipeline constants.
REQ-027 The MEM/WB register SHALL be a sub-module named ldw_MWReg, with load/bubble selection driven by the FSM in ldw_mem_stage.

Verification
REQ-028 ALU op: mwreg=1, malu=0x0000_0040, mrn=3 -> after 1 edge: wwreg=1, walu=0x40, wrn=3, wmo=0; mem_stall never high.
REQ-029 Load: mm2reg=1, malu=0x100, d_ack on the 3rd BUSY cycle with d_rdata=0xDEADBEEF -> mem_stall high for 3 cycles, then wmo=0xDEADBEEF, wm2reg=1.
REQ-030 Store: mwmem=1, malu=0x200, mb=0x1234 -> d_we=1, d_addr=0x200, d_wdata=0x1234 held until ack; then wwreg=0.
REQ-031 Misaligned load: malu=0x102 -> d_req stays 0, one bus_err pulse, bubble in MEM/WB, no stall.
REQ-032 Timeout: load with no ack -> bus_err after 15 BUSY cycles, then IDLE; repeat with ack on cycle 15 -> completion, no bus_err.
REQ-033 clrn pulse mid-BUSY, then late d_ack -> all outputs 0, state IDLE, ack ignored.
